// File: rtl/ex_commit_stage_if.sv
// Handshake bundle between the ALU/issue side and the commit stage, including the writeback port.
// "master" is the surrounding pipeline; "slave" is the commit stage itself.
interface ex_commit_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] alu_result;
  logic [2:0]    alu_flag;
  logic          flag_we;
  logic [2:0]    br_type;
  logic [DW-1:0] br_target;
  logic [DW-1:0] pc_plus4;
  logic [RW-1:0] rd;
  logic          rd_we;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_rd;
  logic          out_rd_we;

  modport master (
    output in_valid, alu_result, alu_flag, flag_we, br_type, br_target, pc_plus4, rd, rd_we,
    output out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_rd_we
  );

  modport slave (
    input  in_valid, alu_result, alu_flag, flag_we, br_type, br_target, pc_plus4, rd, rd_we,
    input  out_ready,
    output in_ready, out_valid, out_data, out_rd, out_rd_we
  );
endinterface

// File: rtl/ex_commit_stage.sv
// Commit stage after the ALU: owns the carry/zero/sign flag register, resolves branches
// into a one-cycle redirect pulse and queues register results in a 2-entry writeback FIFO.
module ex_commit_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  ex_commit_stage_if.slave bus_io,
  output logic [2:0]      flags_o,
  output logic            redirect_o,
  output logic [DW-1:0]   redirect_pc_o
);

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BR   = 3'd1,
    BR_BL   = 3'd2,
    BR_BCY  = 3'd3,
    BR_BNCY = 3'd4,
    BR_BZ   = 3'd5,
    BR_BNZ  = 3'd6,
    BR_BLTZ = 3'd7
  } br_type_e;

  logic [1:0]    count_q, count_d;
  logic          wrPtr_q, rdPtr_q;
  logic [DW-1:0] memData_q [2];
  logic [RW-1:0] memRd_q [2];
  logic [2:0]    flags_q;
  logic          redirect_q;
  logic [DW-1:0] redirectPc_q;
  logic [DW-1:0] outData_q;
  logic [RW-1:0] outRd_q;
  logic          outRdWe_q;

  logic          inReady;
  logic          accept;
  logic          push;
  logic          pop;
  logic          outValid;
  logic          taken;
  logic [DW-1:0] pushData;
  logic          loadHead;
  logic [DW-1:0] headData;
  logic [RW-1:0] headRd;
  br_type_e      brType;

  assign brType   = br_type_e'(bus_io.br_type);
  // The redirect cycle blocks intake so no wrong-path beat can slip in behind a taken branch.
  assign inReady  = (count_q != 2'd2) && !redirect_q;
  assign accept   = bus_io.in_valid && inReady;
  assign push     = accept && bus_io.rd_we;
  assign outValid = (count_q != 2'd0);
  assign pop      = outValid && bus_io.out_ready;
  assign pushData = (brType == BR_BL) ? bus_io.pc_plus4 : bus_io.alu_result;

  // Condition is resolved against the flags held before this edge, not the incoming ones.
  always_comb begin
    taken = 1'b0;
    case (brType)
      BR_NONE: taken = 1'b0;
      BR_BR:   taken = 1'b1;
      BR_BL:   taken = 1'b1;
      BR_BCY:  taken = flags_q[2];
      BR_BNCY: taken = !flags_q[2];
      BR_BZ:   taken = flags_q[1];
      BR_BNZ:  taken = !flags_q[1];
      BR_BLTZ: taken = flags_q[0];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // The head is kept in its own registers so the outputs keep their last value once the FIFO drains.
  always_comb begin
    loadHead = 1'b0;
    headData = memData_q[~rdPtr_q];
    headRd   = memRd_q[~rdPtr_q];
    if (pop) begin
      if (count_q == 2'd2) begin
        loadHead = 1'b1;
      end else if (push) begin
        loadHead = 1'b1;
        headData = pushData;
        headRd   = bus_io.rd;
      end
    end else if ((count_q == 2'd0) && push) begin
      loadHead = 1'b1;
      headData = pushData;
      headRd   = bus_io.rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= 2'd0;
      wrPtr_q      <= 1'b0;
      rdPtr_q      <= 1'b0;
      memData_q[0] <= '0;
      memData_q[1] <= '0;
      memRd_q[0]   <= '0;
      memRd_q[1]   <= '0;
      flags_q      <= 3'b000;
      redirect_q   <= 1'b0;
      redirectPc_q <= '0;
      outData_q    <= '0;
      outRd_q      <= '0;
      outRdWe_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        memData_q[wrPtr_q] <= pushData;
        memRd_q[wrPtr_q]   <= bus_io.rd;
        wrPtr_q            <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      // Only rd_we beats are ever queued, so a loaded head always carries a write enable.
      if (loadHead) begin
        outData_q <= headData;
        outRd_q   <= headRd;
        outRdWe_q <= 1'b1;
      end
      if (accept && bus_io.flag_we) begin
        flags_q <= bus_io.alu_flag;
      end
      redirect_q <= accept && taken;
      if (accept && taken) begin
        redirectPc_q <= bus_io.br_target;
      end
    end
  end

  assign bus_io.in_ready  = inReady;
  assign bus_io.out_valid = outValid;
  assign bus_io.out_data  = outData_q;
  assign bus_io.out_rd    = outRd_q;
  assign bus_io.out_rd_we = outRdWe_q;
  assign flags_o          = flags_q;
  assign redirect_o       = redirect_q;
  assign redirect_pc_o    = redirectPc_q;

endmodule

// File: tb/tb_ex_commit_stage.sv
// Self-checking bench for ex_commit_stage: branch/flag vector table, scoreboarded writeback FIFO
// and hand-written sequences for backpressure, streaming and mid-stream reset.
module tb_ex_commit_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  typedef struct {
    logic [2:0]  brType;
    logic        flagWe;
    logic [2:0]  aluFlag;
    logic        rdWe;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] target;
    logic [31:0] pcPlus4;
    logic        expTaken;
    logic [2:0]  expFlags;
  } vector_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rdWe;
  } wbEntry_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    flags;
  logic          redirect;
  logic [DW-1:0] redirectPc;

  ex_commit_stage_if #(.DW(DW), .RW(RW)) bus ();

  ex_commit_stage #(.DW(DW), .RW(RW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_io       (bus),
    .flags_o      (flags),
    .redirect_o   (redirect),
    .redirect_pc_o(redirectPc)
  );

  always #5 clk = ~clk;

  wbEntry_t    sb[$];
  wbEntry_t    lastHead;
  logic [2:0]  modelFlags;
  logic        expRedirect;
  logic [31:0] expPc;
  int          popCount;
  int          checks = 0;
  int          errors = 0;
  vector_t     table_q[$];

  function automatic vector_t mkVec(input logic [2:0] brType, input logic flagWe, input logic [2:0] aluFlag,
                                    input logic rdWe, input logic [4:0] rd, input logic [31:0] result,
                                    input logic [31:0] target, input logic [31:0] pcPlus4,
                                    input logic expTaken, input logic [2:0] expFlags);
    vector_t v;
    v.brType = brType; v.flagWe = flagWe; v.aluFlag = aluFlag; v.rdWe = rdWe; v.rd = rd;
    v.result = result; v.target = target; v.pcPlus4 = pcPlus4; v.expTaken = expTaken; v.expFlags = expFlags;
    return v;
  endfunction

  function automatic logic branchTaken(input logic [2:0] t, input logic [2:0] f);
    case (t)
      3'd1, 3'd2: return 1'b1;
      3'd3:       return f[2];
      3'd4:       return !f[2];
      3'd5:       return f[1];
      3'd6:       return !f[1];
      3'd7:       return f[0];
      default:    return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    sb.delete();
    lastHead    = '{data: 32'h0, rd: 5'h0, rdWe: 1'b0};
    modelFlags  = 3'b000;
    expRedirect = 1'b0;
    expPc       = 32'h0;
  endtask

  task automatic idleInputs();
    bus.in_valid   = 1'b0;
    bus.alu_result = '0;
    bus.alu_flag   = 3'b000;
    bus.flag_we    = 1'b0;
    bus.br_type    = 3'd0;
    bus.br_target  = '0;
    bus.pc_plus4   = '0;
    bus.rd         = '0;
    bus.rd_we      = 1'b0;
  endtask

  task automatic setBeat(input vector_t v);
    bus.in_valid   = 1'b1;
    bus.alu_result = v.result;
    bus.alu_flag   = v.aluFlag;
    bus.flag_we    = v.flagWe;
    bus.br_type    = v.brType;
    bus.br_target  = v.target;
    bus.pc_plus4   = v.pcPlus4;
    bus.rd         = v.rd;
    bus.rd_we      = v.rdWe;
  endtask

  // Called right after a negedge: checks every output against the model, then advances one clock.
  task automatic tick(output logic acc);
    logic     expInReady;
    logic     popNow;
    logic     tk;
    wbEntry_t head;
    wbEntry_t e;
    #1;
    expInReady = (sb.size() < 2) && !expRedirect;
    head = (sb.size() != 0) ? sb[0] : lastHead;
    checkOutput("in_ready", {31'b0, bus.in_ready}, {31'b0, expInReady});
    checkOutput("out_valid", {31'b0, bus.out_valid}, {31'b0, sb.size() != 0});
    checkOutput("out_data", bus.out_data, head.data);
    checkOutput("out_rd", {27'b0, bus.out_rd}, {27'b0, head.rd});
    checkOutput("out_rd_we", {31'b0, bus.out_rd_we}, {31'b0, head.rdWe});
    checkOutput("flags", {29'b0, flags}, {29'b0, modelFlags});
    checkOutput("redirect", {31'b0, redirect}, {31'b0, expRedirect});
    checkOutput("redirect_pc", redirectPc, expPc);
    acc = bus.in_valid && expInReady;
    popNow = (sb.size() != 0) && bus.out_ready;
    if (sb.size() != 0) lastHead = sb[0];
    if (popNow) begin
      void'(sb.pop_front());
      popCount++;
    end
    if (acc) begin
      tk = branchTaken(bus.br_type, modelFlags);
      expRedirect = tk;
      if (tk) expPc = bus.br_target;
      if (bus.flag_we) modelFlags = bus.alu_flag;
      if (bus.rd_we) begin
        e.data = (bus.br_type == 3'd2) ? bus.pc_plus4 : bus.alu_result;
        e.rd   = bus.rd;
        e.rdWe = 1'b1;
        sb.push_back(e);
      end
    end else begin
      expRedirect = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vector_t v, output logic acc);
    acc = 1'b0;
    setBeat(v);
    for (int k = 0; k < 8 && !acc; k++) tick(acc);
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: beat not accepted, result %0h", v.result);
    end
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 1'b0;
    #1;
    checkOutput("rst out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst in_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("rst flags", {29'b0, flags}, 32'd0);
    checkOutput("rst redirect", {31'b0, redirect}, 32'd0);
    checkOutput("rst redirect_pc", redirectPc, 32'd0);
    checkOutput("rst out_data", bus.out_data, 32'd0);
    checkOutput("rst out_rd_we", {31'b0, bus.out_rd_we}, 32'd0);
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic acc;
    vector_t v;
    int popStart;
    popCount = 0;
    idleInputs();
    bus.out_ready = 1'b1;
    resetModel();
    @(negedge clk);
    doReset();

    // Branch conditions against the flag register, including same-edge flag updates.
    table_q.push_back(mkVec(3'd5, 1, 3'b010, 0, 5'd0,  32'h0,    32'h30, 32'h0,  0, 3'b010));
    table_q.push_back(mkVec(3'd0, 1, 3'b100, 1, 5'd1,  32'h11,   32'h0,  32'h0,  0, 3'b100));
    table_q.push_back(mkVec(3'd3, 0, 3'b000, 0, 5'd0,  32'h0,    32'h40, 32'h0,  1, 3'b100));
    table_q.push_back(mkVec(3'd4, 0, 3'b000, 0, 5'd0,  32'h0,    32'h44, 32'h0,  0, 3'b100));
    table_q.push_back(mkVec(3'd5, 1, 3'b010, 0, 5'd0,  32'h0,    32'h48, 32'h0,  0, 3'b010));
    table_q.push_back(mkVec(3'd5, 0, 3'b000, 0, 5'd0,  32'h0,    32'h50, 32'h0,  1, 3'b010));
    table_q.push_back(mkVec(3'd6, 0, 3'b000, 0, 5'd0,  32'h0,    32'h54, 32'h0,  0, 3'b010));
    table_q.push_back(mkVec(3'd6, 1, 3'b001, 0, 5'd0,  32'h0,    32'h58, 32'h0,  0, 3'b001));
    table_q.push_back(mkVec(3'd7, 0, 3'b000, 0, 5'd0,  32'h0,    32'h5C, 32'h0,  1, 3'b001));
    table_q.push_back(mkVec(3'd1, 1, 3'b110, 0, 5'd0,  32'h0,    32'h60, 32'h0,  1, 3'b110));
    table_q.push_back(mkVec(3'd2, 0, 3'b000, 1, 5'd31, 32'h5,    32'h64, 32'h1C, 1, 3'b110));
    table_q.push_back(mkVec(3'd4, 0, 3'b000, 0, 5'd0,  32'h0,    32'h68, 32'h0,  0, 3'b110));
    table_q.push_back(mkVec(3'd7, 0, 3'b000, 0, 5'd0,  32'h0,    32'h6C, 32'h0,  0, 3'b110));
    table_q.push_back(mkVec(3'd0, 0, 3'b000, 1, 5'd7,  32'hABCD, 32'h0,  32'h0,  0, 3'b110));

    $display("[TB] branch/flag vector table: %0d entries", table_q.size());
    foreach (table_q[i]) begin
      v = table_q[i];
      applyStimulus(v, acc);
      checkOutput($sformatf("vec%0d redirect", i), {31'b0, redirect}, {31'b0, v.expTaken});
      checkOutput($sformatf("vec%0d flags", i), {29'b0, flags}, {29'b0, v.expFlags});
      if (v.expTaken) begin
        checkOutput($sformatf("vec%0d redirect_pc", i), redirectPc, v.target);
        checkOutput($sformatf("vec%0d in_ready", i), {31'b0, bus.in_ready}, 32'd0);
      end
      if (v.rdWe) begin
        checkOutput($sformatf("vec%0d out_data", i), bus.out_data,
                    (v.brType == 3'd2) ? v.pcPlus4 : v.result);
        checkOutput($sformatf("vec%0d out_rd", i), {27'b0, bus.out_rd}, {27'b0, v.rd});
      end
    end
    for (int k = 0; k < 3; k++) tick(acc);

    // Backpressure: fill both entries, hold, then drain while a third beat waits.
    $display("[TB] backpressure sequence");
    bus.out_ready = 1'b0;
    applyStimulus(mkVec(3'd0, 0, 3'b000, 1, 5'd4, 32'd4, 32'h0, 32'h0, 0, 3'b000), acc);
    applyStimulus(mkVec(3'd0, 0, 3'b000, 1, 5'd3, 32'd3, 32'h0, 32'h0, 0, 3'b000), acc);
    checkOutput("bp full in_ready", {31'b0, bus.in_ready}, 32'd0);
    checkOutput("bp head", bus.out_data, 32'd4);
    setBeat(mkVec(3'd0, 0, 3'b000, 1, 5'd5, 32'd5, 32'h0, 32'h0, 0, 3'b000));
    tick(acc);
    tick(acc);
    checkOutput("bp head held", bus.out_data, 32'd4);
    bus.out_ready = 1'b1;
    #1;
    checkOutput("bp pop keeps in_ready low", {31'b0, bus.in_ready}, 32'd0);
    tick(acc);
    checkOutput("bp second head", bus.out_data, 32'd3);
    checkOutput("bp in_ready after pop", {31'b0, bus.in_ready}, 32'd1);
    tick(acc);
    bus.in_valid = 1'b0;
    checkOutput("bp third head", bus.out_data, 32'd5);
    for (int k = 0; k < 3; k++) tick(acc);

    // Streaming with concurrent push and pop.
    $display("[TB] streaming sequence");
    popStart = popCount;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(mkVec(3'd0, 0, 3'b000, 1, 5'(i), 32'(i), 32'h0, 32'h0, 0, 3'b000), acc);
    end
    for (int k = 0; k < 3; k++) tick(acc);
    checkOutput("stream pop count", popCount - popStart, 32'd10);
    checkOutput("stream drained", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("stream last held", bus.out_data, 32'd9);

    // Reset with two buffered entries and a redirect in flight.
    $display("[TB] mid-stream reset sequence");
    bus.out_ready = 1'b0;
    applyStimulus(mkVec(3'd0, 1, 3'b111, 1, 5'd2, 32'hAA, 32'h0,  32'h0, 0, 3'b111), acc);
    applyStimulus(mkVec(3'd1, 0, 3'b000, 1, 5'd3, 32'hBB, 32'h80, 32'h0, 1, 3'b111), acc);
    checkOutput("pre-reset redirect", {31'b0, redirect}, 32'd1);
    doReset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick(acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_commit_stage.md
Name: ex_commit_stage

Overview:
- Sits directly downstream of the ALU and consumes its 32-bit result and 3-bit flag vector.
- Holds the architectural flag register (carry, zero, sign) and resolves branch conditions against it.
- Produces a one-cycle PC redirect for taken branches.
- Buffers completed results in a 2-entry FIFO toward writeback, with valid/ready on both sides.

Parameters:
- DW, 32, data/result/PC width
- RW, 5, destination register index width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- alu_result  in  DW  ALU result
- alu_flag  in  3  ALU flags: [2]=carry, [1]=zero, [0]=sign
- flag_we  in  1  beat updates flag register
- br_type  in  3  0=none, 1=br, 2=bl, 3=bcy, 4=bncy, 5=bz, 6=bnz, 7=bltz
- br_target  in  DW  branch target address
- pc_plus4  in  DW  link value for bl
- rd  in  RW  destination register
- rd_we  in  1  beat writes rd
- out_valid  out  1  writeback beat valid
- out_ready  in  1  writeback accepts
- out_data  out  DW  writeback data
- out_rd  out  RW  writeback register
- out_rd_we  out  1  writeback enable
- flags  out  3  current flag register
- redirect  out  1  taken-branch pulse
- redirect_pc  out  DW  redirect address

Behaviour:
- Reset (async, rst_n=0): FIFO count=0, out_valid=0, in_ready=1, flags=3'b000, redirect=0, redirect_pc=0, out_data=0, out_rd=0, out_rd_we=0. Reset mid-operation discards all buffered beats and any pending redirect.
- Accept: a beat is accepted when in_valid & in_ready are high at a clk edge.
- in_ready = (count<2) & ~redirect. It is forced low in the redirect cycle so wrong-path beats are never accepted; upstream drops its wrong-path beats on redirect.
- Flags: on accept with flag_we=1, flags <= alu_flag at that edge. With flag_we=0, flags hold.
- Branch evaluation: at accept, br_type is evaluated against flags as held before that edge (pre-update value).
  - br: always taken.
  - bl: always taken; the FIFO entry data is pc_plus4.
  - bcy: taken if carry=1. bncy: taken if carry=0.
  - bz: taken if zero=1. bnz: taken if zero=0.
  - bltz: taken if sign=1.
- Taken branch: redirect=1 and redirect_pc=br_target on the cycle after accept, exactly one cycle. redirect_pc holds its last value afterwards.
- FIFO push: an accepted beat pushes an entry only if rd_we=1 (bl forces data=pc_plus4). Otherwise data=alu_result. Beats with rd_we=0 are consumed without an entry.
- FIFO latency: first-word latency is 1 cycle (accept at edge N, out_valid high after edge N).
- FIFO head: out_data/out_rd/out_rd_we present the head entry while out_valid=1. They hold steady while out_valid & ~out_ready.
- Pop: on out_valid & out_ready.
- Simultaneous push and pop: count unchanged, order preserved. With count=2, a pop in the same cycle does not raise in_ready for that cycle, because in_ready is registered from count.
- Full (count=2): in_ready=0, no overwrite.
- Empty: out_valid=0. out_* hold their last values.
- Pointers wrap modulo 2.
- Arithmetic: none beyond pass-through; widths are exact, no extension.

Test Plan:
- Reset then idle: rst_n low mid-stream with 2 entries buffered -> out_valid=0, flags=000, in_ready=1 immediately; no redirect after release.
- Flag update then bcy: beat1 flag_we=1, alu_flag=3'b100, rd_we=0; beat2 br_type=3, br_target=32'h40 -> redirect=1 for exactly one cycle, redirect_pc=32'h40; in_ready=0 during that cycle.
- Same-edge ordering: beat with flag_we=1, alu_flag=3'b010 and br_type=5 while flags=000 -> not taken (pre-update flags used); flags=010 afterwards.
- bl link: br_type=2, pc_plus4=32'h1C, rd=31, rd_we=1, alu_result=32'h5 -> out_data=32'h1C, out_rd=31; redirect pulse to br_target.
- Backpressure: out_ready=0, push results 4 and 3 -> count=2, in_ready=0, out_data=4 stable; raise out_ready -> 4 then 3 in order.
- Simultaneous push/pop at count=1 over 10 beats of results 0..9 -> out_data sequence 0..9, no loss or duplication.
